// File: rtl/pipe_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_run_ctrl                                                   |
// | Brief    : Run/step/burst/breakpoint controller producing the pipeline      |
// |            advance enable, plus cycle and retired-instruction counters.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pipe_run_ctrl #(
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_btn,
  input  logic             run_btn,
  input  logic             burst_btn,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc_if,
  input  logic             wb_bubble,
  output logic             pipe_en,
  output logic [1:0]       ctrl_state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int c_BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [c_BW-1:0] c_BURST_LOAD = c_BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_STEP  = 2'b01,
    S_RUN   = 2'b10,
    S_BURST = 2'b11
  } state_t;

  state_t            r_state;
  logic [c_BW-1:0]   r_burst_cnt;
  logic              r_skip;
  logic              r_bp_hit;
  logic              r_step_q;
  logic              r_run_q;
  logic              r_burst_q;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic w_step_pulse;
  logic w_run_pulse;
  logic w_burst_pulse;
  logic w_bp_match;
  logic w_pipe_en;

  assign w_step_pulse  = step_btn  & ~r_step_q;
  assign w_run_pulse   = run_btn   & ~r_run_q;
  assign w_burst_pulse = burst_btn & ~r_burst_q;

  // skip masks the breakpoint so a resume can advance past the stopped instruction
  assign w_bp_match = bp_en & (pc_if == bp_addr) & ~r_skip;

  always_comb begin
    w_pipe_en = 1'b0;
    case (r_state)
      S_STEP:          w_pipe_en = 1'b1;
      S_RUN, S_BURST:  w_pipe_en = ~w_bp_match;
      default:         w_pipe_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HALT;
      r_burst_cnt <= '0;
      r_skip      <= 1'b0;
      r_bp_hit    <= 1'b0;
      r_step_q    <= 1'b0;
      r_run_q     <= 1'b0;
      r_burst_q   <= 1'b0;
    end else begin
      r_step_q  <= step_btn;
      r_run_q   <= run_btn;
      r_burst_q <= burst_btn;
      if (w_pipe_en) begin
        r_skip <= 1'b0;
      end
      case (r_state)
        S_HALT: begin
          if (w_run_pulse) begin
            r_state  <= S_RUN;
            r_skip   <= 1'b1;
            r_bp_hit <= 1'b0;
          end else if (w_burst_pulse) begin
            r_state     <= S_BURST;
            r_burst_cnt <= c_BURST_LOAD;
            r_skip      <= 1'b1;
            r_bp_hit    <= 1'b0;
          end else if (w_step_pulse) begin
            r_state  <= S_STEP;
            r_skip   <= 1'b1;
            r_bp_hit <= 1'b0;
          end
        end
        S_STEP: begin
          r_state <= S_HALT;
        end
        S_RUN: begin
          if (w_bp_match) begin
            r_state  <= S_HALT;
            r_bp_hit <= 1'b1;
          end else if (w_run_pulse) begin
            r_state <= S_HALT;
          end
        end
        S_BURST: begin
          if (w_bp_match) begin
            r_state  <= S_HALT;
            r_bp_hit <= 1'b1;
          end else if (w_run_pulse) begin
            r_state <= S_HALT;
          end else if (r_burst_cnt == '0) begin
            r_state <= S_HALT;
          end else begin
            r_burst_cnt <= r_burst_cnt - 1'b1;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
    end else if (w_pipe_en) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (!wb_bubble) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
    end
  end

  assign pipe_en    = w_pipe_en;
  assign ctrl_state = r_state;
  assign bp_hit     = r_bp_hit;
  assign cycle_cnt  = r_cycle_cnt;
  assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipe_run_ctrl                                                |
// | Brief    : Self-checking bench for pipe_run_ctrl (vectors, directed, random)|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pipe_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step_btn = 1'b0, run_btn = 1'b0, burst_btn = 1'b0;
  logic        bp_en = 1'b0, wb_bubble = 1'b0;
  logic [31:0] bp_addr = '0, pc_if = '0;

  logic        pipe_en, bp_hit;
  logic [1:0]  ctrl_state;
  logic [31:0] cycle_cnt, retire_cnt;
  logic        s_pipe_en, s_bp_hit;
  logic [1:0]  s_ctrl_state;
  logic [3:0]  s_cycle_cnt, s_retire_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_run_ctrl #(.BURST_LEN(16), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .step_btn(step_btn), .run_btn(run_btn),
    .burst_btn(burst_btn), .bp_en(bp_en), .bp_addr(bp_addr), .pc_if(pc_if),
    .wb_bubble(wb_bubble), .pipe_en(pipe_en), .ctrl_state(ctrl_state),
    .bp_hit(bp_hit), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  pipe_run_ctrl #(.BURST_LEN(3), .CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .step_btn(step_btn), .run_btn(run_btn),
    .burst_btn(burst_btn), .bp_en(bp_en), .bp_addr(bp_addr), .pc_if(pc_if),
    .wb_bubble(wb_bubble), .pipe_en(s_pipe_en), .ctrl_state(s_ctrl_state),
    .bp_hit(s_bp_hit), .cycle_cnt(s_cycle_cnt), .retire_cnt(s_retire_cnt)
  );

  // Behavioural model: mode 0 halt, 1 step, 2 run, 3 burst; left = enabled burst cycles remaining
  typedef struct packed {
    logic [1:0]  mode;
    int          left;
    logic        skip, hit, ps, pr, pb;
    logic [31:0] cyc, ret;
  } mdl_t;

  typedef struct packed {
    logic s, r, b, bub;
    logic en;
    logic [1:0] st;
    logic [31:0] cyc, ret;
    logic hit;
  } vec_t;

  function automatic logic m_match(input mdl_t m, input logic be, input logic [31:0] ba, pc);
    return be && (pc == ba) && !m.skip;
  endfunction

  function automatic logic m_en(input mdl_t m, input logic be, input logic [31:0] ba, pc);
    if (m.mode == 2'd1) return 1'b1;
    if (m.mode >= 2'd2) return !m_match(m, be, ba, pc);
    return 1'b0;
  endfunction

  function automatic mdl_t m_next(input mdl_t m, input logic s, r, b, be,
                                  input logic [31:0] ba, pc, input logic bub, input int blen);
    mdl_t n = m;
    logic en = m_en(m, be, ba, pc);
    logic hitm = m_match(m, be, ba, pc);
    logic ps = s && !m.ps, pr = r && !m.pr, pb = b && !m.pb;
    if (en) begin
      n.cyc  = m.cyc + 1;
      n.ret  = bub ? m.ret : m.ret + 1;
      n.skip = 1'b0;
    end
    case (m.mode)
      2'd0: begin
        if (pr) n.mode = 2'd2;
        else if (pb) begin n.mode = 2'd3; n.left = blen; end
        else if (ps) n.mode = 2'd1;
        if (pr || pb || ps) begin n.skip = 1'b1; n.hit = 1'b0; end
      end
      2'd1: n.mode = 2'd0;
      default: begin
        if (hitm) begin n.mode = 2'd0; n.hit = 1'b1; end
        else if (pr) n.mode = 2'd0;
        else if (m.mode == 2'd3) begin
          n.left = m.left - 1;
          if (n.left == 0) n.mode = 2'd0;
        end
      end
    endcase
    n.ps = s; n.pr = r; n.pb = b;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, r, b, be, input logic [31:0] ba, pc, input logic bub);
    @(negedge clk);
    step_btn = s; run_btn = r; burst_btn = b;
    bp_en = be; bp_addr = ba; pc_if = pc; wb_bubble = bub;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step_btn = 0; run_btn = 0; burst_btn = 0; bp_en = 0; bp_addr = '0; pc_if = '0; wb_bubble = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[13];
  mdl_t mm, ms;
  logic [31:0] pcv;
  logic rs, rr, rb, rbe, rbub;
  logic [31:0] rba, rpc;

  initial begin
    //          s r b bub en st    cyc    ret   hit
    tbl[0]  = '{0,0,0,0, 0,2'd0, 32'd0, 32'd0, 0};
    tbl[1]  = '{1,0,0,0, 0,2'd0, 32'd0, 32'd0, 0};
    tbl[2]  = '{1,0,0,0, 1,2'd1, 32'd0, 32'd0, 0};
    tbl[3]  = '{1,0,0,0, 0,2'd0, 32'd1, 32'd1, 0};
    tbl[4]  = '{1,0,0,0, 0,2'd0, 32'd1, 32'd1, 0};
    tbl[5]  = '{0,0,0,0, 0,2'd0, 32'd1, 32'd1, 0};
    tbl[6]  = '{1,1,0,0, 0,2'd0, 32'd1, 32'd1, 0};
    tbl[7]  = '{1,1,0,0, 1,2'd2, 32'd1, 32'd1, 0};
    tbl[8]  = '{0,1,0,1, 1,2'd2, 32'd2, 32'd2, 0};
    tbl[9]  = '{0,0,0,0, 1,2'd2, 32'd3, 32'd2, 0};
    tbl[10] = '{0,1,0,0, 1,2'd2, 32'd4, 32'd3, 0};
    tbl[11] = '{0,1,0,0, 0,2'd0, 32'd5, 32'd4, 0};
    tbl[12] = '{0,0,0,0, 0,2'd0, 32'd5, 32'd4, 0};

    // Vector table: reset state, single step with held button, run/step priority, run stop
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].s, tbl[i].r, tbl[i].b, 1'b0, 32'h0, 32'h0, tbl[i].bub);
      chk($sformatf("vec%0d_en", i), {31'b0, pipe_en}, {31'b0, tbl[i].en});
      chk($sformatf("vec%0d_st", i), {30'b0, ctrl_state}, {30'b0, tbl[i].st});
      chk($sformatf("vec%0d_cyc", i), cycle_cnt, tbl[i].cyc);
      chk($sformatf("vec%0d_ret", i), retire_cnt, tbl[i].ret);
      chk($sformatf("vec%0d_hit", i), {31'b0, bp_hit}, {31'b0, tbl[i].hit});
    end

    // Burst of 16 with 4 bubbles
    do_reset();
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("burst_start_en", {31'b0, pipe_en}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 0, 0, 0, (i >= 4 && i < 8));
      chk("burst_en", {31'b0, pipe_en}, 32'd1);
      chk("burst_st", {30'b0, ctrl_state}, 32'd3);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("burst_end_en", {31'b0, pipe_en}, 32'd0);
    chk("burst_end_st", {30'b0, ctrl_state}, 32'd0);
    chk("burst_cyc", cycle_cnt, 32'd16);
    chk("burst_ret", retire_cnt, 32'd12);

    // Breakpoint stop and resume past it
    do_reset();
    pcv = 32'h0;
    drive(0, 1, 0, 1, 32'h10, pcv, 0);
    chk("bp_pulse_en", {31'b0, pipe_en}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 1, 32'h10, pcv, 0);
      chk("bp_run_en", {31'b0, pipe_en}, 32'd1);
      pcv = pcv + 32'd4;
    end
    drive(0, 1, 0, 1, 32'h10, pcv, 0);
    chk("bp_stop_en", {31'b0, pipe_en}, 32'd0);
    drive(0, 1, 0, 1, 32'h10, pcv, 0);
    chk("bp_halt_st", {30'b0, ctrl_state}, 32'd0);
    chk("bp_hit_set", {31'b0, bp_hit}, 32'd1);
    drive(0, 0, 0, 1, 32'h10, pcv, 0);
    drive(0, 1, 0, 1, 32'h10, pcv, 0);
    chk("bp_resume_pulse_en", {31'b0, pipe_en}, 32'd0);
    drive(0, 1, 0, 1, 32'h10, pcv, 0);
    chk("bp_resume_en", {31'b0, pipe_en}, 32'd1);
    chk("bp_resume_hit", {31'b0, bp_hit}, 32'd0);
    chk("bp_resume_st", {30'b0, ctrl_state}, 32'd2);
    pcv = pcv + 32'd4;
    drive(0, 1, 0, 1, 32'h10, pcv, 0);
    chk("bp_past_en", {31'b0, pipe_en}, 32'd1);
    chk("bp_cyc", cycle_cnt, 32'd5);

    // Counter wrap on the 4-bit instance: 17 single steps
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      if (i == 14) begin
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_pre_small", {28'b0, s_cycle_cnt}, 32'd15);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_small_cyc", {28'b0, s_cycle_cnt}, 32'd1);
    chk("wrap_small_ret", {28'b0, s_retire_cnt}, 32'd1);
    chk("wrap_main_cyc", cycle_cnt, 32'd17);

    // Asynchronous reset in the middle of a burst
    do_reset();
    drive(0, 0, 1, 0, 0, 0, 0);
    repeat (5) drive(0, 0, 1, 0, 0, 0, 0);
    chk("arst_pre_en", {31'b0, pipe_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", {31'b0, pipe_en}, 32'd0);
    chk("arst_st", {30'b0, ctrl_state}, 32'd0);
    chk("arst_cyc", cycle_cnt, 32'd0);
    chk("arst_ret", retire_cnt, 32'd0);
    chk("arst_small_cyc", {28'b0, s_cycle_cnt}, 32'd0);

    // Randomized run against the model, both instances
    do_reset();
    mm = '0; ms = '0;
    rs = 0; rr = 0; rb = 0; rbe = 0; rba = 32'h20;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0)  rs = ~rs;
      if ($urandom_range(0, 15) == 0) rr = ~rr;
      if ($urandom_range(0, 11) == 0) rb = ~rb;
      if ($urandom_range(0, 63) == 0) rbe = ~rbe;
      if ($urandom_range(0, 127) == 0) rba = 32'($urandom_range(0, 7)) << 4;
      rpc  = 32'($urandom_range(0, 7)) << 4;
      rbub = ($urandom_range(0, 3) == 0);
      drive(rs, rr, rb, rbe, rba, rpc, rbub);
      chk("rnd_en", {31'b0, pipe_en}, {31'b0, m_en(mm, rbe, rba, rpc)});
      chk("rnd_st", {30'b0, ctrl_state}, {30'b0, mm.mode});
      chk("rnd_hit", {31'b0, bp_hit}, {31'b0, mm.hit});
      chk("rnd_cyc", cycle_cnt, mm.cyc);
      chk("rnd_ret", retire_cnt, mm.ret);
      chk("rnd_s_en", {31'b0, s_pipe_en}, {31'b0, m_en(ms, rbe, rba, rpc)});
      chk("rnd_s_st", {30'b0, s_ctrl_state}, {30'b0, ms.mode});
      chk("rnd_s_hit", {31'b0, s_bp_hit}, {31'b0, ms.hit});
      chk("rnd_s_cyc", {28'b0, s_cycle_cnt}, {28'b0, ms.cyc[3:0]});
      chk("rnd_s_ret", {28'b0, s_retire_cnt}, {28'b0, ms.ret[3:0]});
      mm = m_next(mm, rs, rr, rb, rbe, rba, rpc, rbub, 16);
      ms = m_next(ms, rs, rr, rb, rbe, rba, rpc, rbub, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
